// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: shares one router local injection port among NUM_REQ
// flit sources. Round-robin, packet-atomic arbitration: a grant is held from
// the header flit through the tail flit. One registered output stage drives
// the router.

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `Noc_Data_Width,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic [15:0]               pkt_count,
  output logic                      err_drop
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state;
  logic [GID_W-1:0]   rr_ptr;

  logic               slot_free;
  logic [NUM_REQ-1:0] drop_mask;
  logic               win_found;
  logic [GID_W-1:0]   win_id;
  logic               acc;
  logic               acc_tail;
  logic [DATA_W-1:0]  acc_flit;
  logic               acc_hdr;
  logic [GID_W-1:0]   next_ptr;

  // The output register can take a new flit if empty or draining this edge.
  assign slot_free = !out_valid || out_ready;

  // While idle, any non-header flit is a protocol error: accept and discard it.
  assign drop_mask = (state == IDLE) ? (req_valid & ~req_is_header) : '0;

  // Flit from the locked requester, accepted when the output slot is free.
  assign acc      = (state == LOCKED) && req_valid[grant_id] && slot_free;
  assign acc_tail = req_is_tail[grant_id];
  assign acc_hdr  = req_is_header[grant_id];
  assign acc_flit = req_flit[grant_id*DATA_W +: DATA_W];

  // Pointer advances to the requester after the one that just finished.
  assign next_ptr = (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Round-robin winner search among header-presenting requesters from rr_ptr.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[idx] && req_is_header[idx]) begin
        win_found = 1'b1;
        win_id    = GID_W'(idx);
      end
    end
  end

  // Per-requester ready: drop path when idle, slot availability for the owner when locked.
  always_comb begin
    req_ready = '0;
    if (state == IDLE) begin
      req_ready = drop_mask;
    end else begin
      req_ready[grant_id] = slot_free;
    end
    // Held at 0 during reset so the sources see no accept while the block is cleared.
    if (!noc_rst_n) begin
      req_ready = '0;
    end
  end

  // Arbitration FSM with its registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      pkt_count <= '0;
      err_drop  <= 1'b0;
    end else begin
      // Several simultaneous drops still produce a single one-cycle pulse.
      err_drop <= |drop_mask;
      case (state)
        IDLE: begin
          // The grant edge consumes no flit; the header is taken on the next edge.
          if (win_found) begin
            state    <= LOCKED;
            grant_id <= win_id;
            busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (acc && acc_tail) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rr_ptr    <= next_ptr;
            pkt_count <= pkt_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single output register toward the router; holds its flit while stalled.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      out_valid     <= 1'b0;
      out_flit      <= '0;
      out_is_header <= 1'b0;
      out_is_tail   <= 1'b0;
    end else if (acc) begin
      out_valid     <= 1'b1;
      out_flit      <= acc_flit;
      out_is_header <= acc_hdr;
      out_is_tail   <= acc_tail;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
